// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Turns decoded instruction fields into 32-bit MIPS words and streams them
//   into an instruction memory, one word at a time, starting at a base
//   address chosen when a load session is opened.
//
// Ports
//   clk, rst              clock (rising edge) / async active-high reset
//   load_start, load_stop session control pulses (load_start wins)
//   base_addr             first word address of a new session
//   in_valid / in_ready   field handshake (in_ready only while READY)
//   op_sel                operation select, 0..16 legal, 17..31 illegal
//   rs, rt, rd, imm,
//   target                instruction fields
//   wr_en, wr_addr,
//   wr_data               registered instruction-memory write port
//   count                 words written in the current session
//   full                  the last address (1023) has been written
//   err                   sticky: an illegal op_sel was accepted
// ---------------------------------------------------------------------------
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        load_stop,
    input  logic [9:0]  base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        wr_en,
    output logic [9:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [10:0] count,
    output logic        full,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_WRITE = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    // One bit wider than the address space so "written 1023" is visible
    // as bit 10 instead of wrapping back to 0.
    logic [10:0] addr_q, addr_d;
    logic [10:0] count_q, count_d;
    logic        wr_en_q, wr_en_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        in_ready_q, in_ready_d;
    logic        full_q, full_d;
    logic        err_q, err_d;

    // -----------------------------------------------------------------------
    // Encoder
    // -----------------------------------------------------------------------
    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] f);
        return {6'b000000, s, t, d, 5'b00000, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] i);
        return {opc, s, t, i};
    endfunction

    logic [31:0] enc_word;
    logic        enc_legal;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (op_sel)
            5'd0:  enc_word = rtype(rs, rt, rd, 6'b100000);     // ADD
            5'd1:  enc_word = rtype(rs, rt, rd, 6'b100010);     // SUB
            5'd2:  enc_word = rtype(rs, rt, rd, 6'b100100);     // AND
            5'd3:  enc_word = rtype(rs, rt, rd, 6'b100101);     // OR
            5'd4:  enc_word = rtype(rs, rt, rd, 6'b101010);     // SLT
            // HI/LO producers have no destination register field
            5'd5:  enc_word = rtype(rs, rt, 5'd0, 6'b011000);   // MULT
            5'd6:  enc_word = rtype(rs, rt, 5'd0, 6'b011001);   // MULTU
            5'd7:  enc_word = rtype(rs, rt, 5'd0, 6'b011010);   // DIV
            5'd8:  enc_word = rtype(rs, rt, 5'd0, 6'b011011);   // DIVU
            // HI/LO readers take no source registers
            5'd9:  enc_word = rtype(5'd0, 5'd0, rd, 6'b010000); // MFHI
            5'd10: enc_word = rtype(5'd0, 5'd0, rd, 6'b010010); // MFLO
            5'd11: enc_word = itype(6'b100011, rs, rt, imm);    // LW
            5'd12: enc_word = itype(6'b101011, rs, rt, imm);    // SW
            5'd13: enc_word = itype(6'b000100, rs, rt, imm);    // BEQ
            5'd14: enc_word = itype(6'b000101, rs, rt, imm);    // BNE
            5'd15: enc_word = itype(6'b001000, rs, rt, imm);    // ADDI
            5'd16: enc_word = {6'b000011, target};              // JAL
            default: enc_legal = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Session / write control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;          // write strobe is a single-cycle pulse
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;

        if (load_start) begin
            // Any write already on the port this cycle still completes,
            // because wr_en_q is registered and only falls after this edge.
            state_d = S_READY;
            addr_d  = {1'b0, base_addr};
            count_d = '0;
            err_d   = 1'b0;
        end else if (load_stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_READY: begin
                    if (in_valid) begin
                        if (enc_legal) begin
                            state_d   = S_WRITE;
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q[9:0];
                            wr_data_d = enc_word;
                            addr_d    = addr_q + 11'd1;
                            count_d   = count_q + 11'd1;
                        end else begin
                            // Illegal op is consumed but leaves no trace
                            // other than the sticky flag.
                            err_d = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    // addr_q already points past the word being written;
                    // bit 10 set means address 1023 was just used.
                    state_d = addr_q[10] ? S_FULL : S_READY;
                end
                default: ;
            endcase
        end

        in_ready_d = (state_d == S_READY);
        full_d     = (state_d == S_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            in_ready_q <= 1'b0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= in_ready_d;
            full_q     <= full_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign count    = count_q;
    assign full     = full_q;
    assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start, load_stop;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op_sel, rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [10:0] count;
    logic        full, err;

    int n_vec = 0;
    int n_err = 0;

    instr_encoder dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_stop(load_stop), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance one clock, land 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [9:0] base);
        load_start = 1'b1;
        base_addr  = base;
        tick();
        load_start = 1'b0;
    endtask

    task automatic offer(input logic [4:0] op, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [15:0] i, input logic [25:0] tg);
        op_sel = op; rs = s; rt = t; rd = d; imm = i; target = tg;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // offer a legal op from READY and check the resulting write cycle,
    // then step back to READY
    task automatic write_chk(input string tag, input logic [4:0] op, input logic [4:0] s,
                             input logic [4:0] t, input logic [4:0] d, input logic [15:0] i,
                             input logic [25:0] tg, input logic [9:0] ea,
                             input logic [31:0] ed, input logic [10:0] ec);
        offer(op, s, t, d, i, tg);
        chk({tag, ".wr_en"},   {31'd0, wr_en},    32'd1);
        chk({tag, ".addr"},    {22'd0, wr_addr},  {22'd0, ea});
        chk({tag, ".data"},    wr_data,           ed);
        chk({tag, ".count"},   {21'd0, count},    {21'd0, ec});
        chk({tag, ".ready0"},  {31'd0, in_ready}, 32'd0);
        tick();
        chk({tag, ".wr_en0"},  {31'd0, wr_en},    32'd0);
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; load_stop = 1'b0; base_addr = '0;
        in_valid = 1'b0; op_sel = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;
        tick();
        chk("rst.ready", {31'd0, in_ready}, 32'd0);
        chk("rst.wr_en", {31'd0, wr_en},    32'd0);
        chk("rst.count", {21'd0, count},    32'd0);
        chk("rst.flags", {30'd0, full, err}, 32'd0);
        rst = 1'b0;
        tick();

        // in_valid ignored in IDLE
        offer(5'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        chk("idle.ignore", {31'd0, wr_en}, 32'd0);

        // basic ADDI
        start(10'd0);
        chk("start.ready", {31'd0, in_ready}, 32'd1);
        write_chk("addi", 5'd15, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0, 10'd0, 32'h2008_0005, 11'd1);

        // back-to-back ADD / LW, 2 cycles apart
        start(10'd0);
        chk("restart.count", {21'd0, count}, 32'd0);
        write_chk("add", 5'd0,  5'd1,  5'd2, 5'd3, 16'd0, 26'd0, 10'd0, 32'h0022_1820, 11'd1);
        write_chk("lw",  5'd11, 5'd29, 5'd2, 5'd0, 16'd4, 26'd0, 10'd1, 32'h8FA2_0004, 11'd2);

        // forced fields and J-type
        write_chk("mult", 5'd5,  5'd4, 5'd5, 5'd7, 16'd0, 26'd0,    10'd2, 32'h0085_0018, 11'd3);
        write_chk("mfhi", 5'd9,  5'd3, 5'd7, 5'd9, 16'd0, 26'd0,    10'd3, 32'h0000_4810, 11'd4);
        write_chk("jal",  5'd16, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10,   10'd4, 32'h0C00_0010, 11'd5);
        write_chk("sw",   5'd12, 5'd1, 5'd2, 5'd0, 16'hFFFC, 26'd0, 10'd5, 32'hAC22_FFFC, 11'd6);

        // illegal op: no write, sticky err, address and count kept
        offer(5'd20, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0);
        chk("ill.wr_en", {31'd0, wr_en},    32'd0);
        chk("ill.err",   {31'd0, err},      32'd1);
        chk("ill.count", {21'd0, count},    32'd6);
        chk("ill.ready", {31'd0, in_ready}, 32'd1);
        write_chk("post_ill", 5'd15, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0, 10'd6, 32'h2008_0005, 11'd7);
        chk("ill.sticky", {31'd0, err}, 32'd1);

        // load_stop back to IDLE; fields ignored there
        load_stop = 1'b1; tick(); load_stop = 1'b0;
        chk("stop.ready", {31'd0, in_ready}, 32'd0);
        offer(5'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        chk("stop.ignore", {31'd0, wr_en}, 32'd0);

        // top of address space
        start(10'd1022);
        chk("hi.err_clr", {31'd0, err}, 32'd0);
        write_chk("hi0", 5'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 10'd1022, 32'h0022_1820, 11'd1);
        write_chk("hi1", 5'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 10'd1023, 32'h0022_1822, 11'd2);
        chk("hi.full",  {31'd0, full},     32'd1);
        chk("hi.ready", {31'd0, in_ready}, 32'd0);
        offer(5'd2, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        chk("hi.nowr",  {31'd0, wr_en},    32'd0);
        chk("hi.count", {21'd0, count},    32'd2);
        start(10'd5);
        chk("hi.full_clr", {31'd0, full},     32'd0);
        chk("hi.ready1",   {31'd0, in_ready}, 32'd1);

        // load_start during WRITE: write still visible, then new session
        offer(5'd3, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        chk("ls.wr_en", {31'd0, wr_en},   32'd1);
        chk("ls.data",  wr_data,          32'h0022_1825);
        chk("ls.addr",  {22'd0, wr_addr}, 32'd5);
        start(10'd100);
        chk("ls.count", {21'd0, count},    32'd0);
        chk("ls.ready", {31'd0, in_ready}, 32'd1);
        chk("ls.wr_en0", {31'd0, wr_en},   32'd0);

        // async reset mid-WRITE
        offer(5'd4, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        chk("rw.wr_en", {31'd0, wr_en},   32'd1);
        chk("rw.addr",  {22'd0, wr_addr}, 32'd100);
        chk("rw.data",  wr_data,          32'h0022_182A);
        #2 rst = 1'b1;
        #1;
        chk("rw.wr_en0", {31'd0, wr_en},   32'd0);
        chk("rw.addr0",  {22'd0, wr_addr}, 32'd0);
        chk("rw.data0",  wr_data,          32'd0);
        chk("rw.count0", {21'd0, count},   32'd0);
        chk("rw.ready0", {31'd0, in_ready}, 32'd0);
        chk("rw.flags0", {30'd0, full, err}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_start  in  1  pulse: open load session at base_addr, clear count/err.
- load_stop  in  1  pulse: close session.
- base_addr  in  10  first instruction-memory word address.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept fields.
- op_sel  in  5  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 MULT, 6 MULTU, 7 DIV, 8 DIVU, 9 MFHI, 10 MFLO, 11 LW, 12 SW, 13 BEQ, 14 BNE, 15 ADDI, 16 JAL, 17-31 illegal.
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  immediate/offset.
- target  in  26  JAL target.
- wr_en  out  1  instruction-memory write strobe.
- wr_addr  out  10  write word address.
- wr_data  out  32  encoded MIPS word.
- count  out  11  words written this session.
- full  out  1  address space exhausted.
- err  out  1  sticky illegal-op flag.

Function
REQ-002 SHALL implement states IDLE, READY, WRITE, FULL; in_ready=1 only in READY.
REQ-003 SHALL enter READY from any state on load_start, with next-write address=base_addr, count=0, err=0, full=0.
REQ-004 SHALL give load_start priority over load_stop; load_stop alone SHALL return to IDLE.
REQ-005 SHALL capture fields on the edge where in_valid&in_ready; SHALL then enter WRITE and drive wr_en=1 for exactly the following cycle, with wr_addr and wr_data registered.
REQ-006 SHALL sustain throughput of one word per 2 cycles; in_ready=0 during WRITE.
REQ-007 SHALL encode R-type ops 0-10 as {000000,rs,rt,rd,00000,func}.
- R-type func codes: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MFLO 010010.
REQ-008 SHALL force rd=0 for MULT/MULTU/DIV/DIVU, and rs=0 and rt=0 for MFHI/MFLO.
REQ-009 SHALL encode I-type ops as {opcode,rs,rt,imm}: LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000.
REQ-010 SHALL encode JAL as {000011,target}.
REQ-011 SHALL handle an accepted illegal op_sel (17-31) as follows: no write, err set (sticky until load_start or rst), count and address unchanged, state stays READY.
REQ-012 SHALL, after each write, increment the address by 1 and count by 1.
REQ-013 SHALL, after a write at address 1023, go to FULL (full=1, in_ready=0) with no wrap, until load_start.
REQ-014 SHALL, when load_start arrives during WRITE, still emit that cycle's write, then enter READY at the new base_addr with count=0.
REQ-015 SHALL, when load_stop arrives during WRITE, still emit the write, then enter IDLE.
REQ-016 SHALL ignore in_valid in IDLE, WRITE and FULL.

Reset
REQ-017 SHALL, on rst (asynchronous), immediately enter IDLE with in_ready=0, wr_en=0, wr_addr=0, wr_data=0, count=0, full=0, err=0.
REQ-018 SHALL, on rst asserted mid-WRITE, drop wr_en immediately; no partial write is retried.

Verification
REQ-019 SHALL cover load_start base=0; ADDI rs=0 rt=8 imm=5 -> one cycle later wr_en=1, wr_addr=0, wr_data=0x20080005, count=1.
REQ-020 SHALL cover ADD rs=1 rt=2 rd=3 then LW rs=29 rt=2 imm=4 back-to-back -> writes 0x00221820 @0, 0x8FA20004 @1, 2 cycles apart.
REQ-021 SHALL cover MULT rs=4 rt=5 rd=7 -> 0x00850018; MFHI rs=3 rd=9 -> 0x00004810; JAL target=0x10 -> 0x0C000010.
REQ-022 SHALL cover op_sel=20 accepted -> no wr_en, err=1, count unchanged; next legal op is written at the unchanged address.
REQ-023 SHALL cover base=1022, three ops offered -> writes @1022 and @1023, then full=1, in_ready=0, count=2; load_start clears full.
REQ-024 SHALL cover rst asserted during WRITE -> wr_en falls without a clock edge and all outputs return to reset values.
